// File: rtl/pipe_sel_mux.sv
// pipe_sel_mux: registered channel selector with a two-entry (main + skid)
// valid/ready output stage. Supports binary or one-hot priority select.
module pipe_sel_mux #(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      NUM_IN      = 4,
  parameter int unsigned      ONEHOT      = 0,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0,
  localparam int unsigned     SEL_W       = (ONEHOT != 0) ? NUM_IN : $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        dout,
  output logic                    sel_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic             main_err_q, main_err_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             skid_err_q, skid_err_d;
  logic             in_ready_q, out_valid_q;

  logic [WIDTH-1:0] sel_data_c;
  logic             sel_err_c;
  logic             accept_c;

  generate
    if (ONEHOT != 0) begin : g_onehot
      // One-hot priority select: scan downward so the lowest set bit wins last.
      always_comb begin
        sel_data_c = DEFAULT_VAL;
        sel_err_c  = 1'b1;
        for (int k = int'(NUM_IN) - 1; k >= 0; k--) begin
          if (sel[k]) begin
            sel_data_c = din[k*WIDTH +: WIDTH];
            sel_err_c  = 1'b0;
          end
        end
      end
    end else begin : g_binary
      // Binary select: codes at or above NUM_IN fall through to the default value.
      always_comb begin
        sel_data_c = DEFAULT_VAL;
        sel_err_c  = 1'b1;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
          if (sel == SEL_W'(k)) begin
            sel_data_c = din[k*WIDTH +: WIDTH];
            sel_err_c  = 1'b0;
          end
        end
      end
    end
  endgenerate

  assign accept_c = in_valid & in_ready_q & ~flush;

  // Next-state and storage steering for the main/skid pair.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_err_d  = main_err_q;
    skid_data_d = skid_data_q;
    skid_err_d  = skid_err_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_c) begin
            state_d     = ST_ONE;
            main_data_d = sel_data_c;
            main_err_d  = sel_err_c;
          end
        end
        ST_ONE: begin
          if (accept_c && out_ready) begin
            main_data_d = sel_data_c;
            main_err_d  = sel_err_c;
          end else if (accept_c) begin
            state_d     = ST_FULL;
            skid_data_d = sel_data_c;
            skid_err_d  = sel_err_c;
          end else if (out_ready) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            state_d     = ST_ONE;
            main_data_d = skid_data_q;
            main_err_d  = skid_err_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State, storage and handshake flags; handshake flags track the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_err_q  <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_err_q  <= main_err_d;
      skid_data_q <= skid_data_d;
      skid_err_q  <= skid_err_d;
      in_ready_q  <= (state_d != ST_FULL);
      out_valid_q <= (state_d != ST_EMPTY);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign dout      = main_data_q;
  assign sel_err   = main_err_q;

endmodule
